// File: rtl/unified_sram_arbiter.sv
// Arbitrates instruction-fetch and data accesses onto one single-ported synchronous SRAM.
// Optional build macro ARB_KSEG_MAP_EN folds kseg0/kseg1 addresses onto the physical SRAM.
module unified_sram_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ack,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ack,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        if_stall,
  output logic        mem_stall
);

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIM);

  logic              inst_grant;
  logic              data_grant;
  logic              read_issue;
  logic [3:0]        streak_reg;
  logic [3:0]        streak_next;
  logic [RD_LAT-1:0] valid_reg;
  logic [RD_LAT-1:0] valid_next;
  logic [RD_LAT-1:0] owner_reg;   // 1 = data port owns the response
  logic [RD_LAT-1:0] owner_next;
  logic [31:0]       grant_addr;
  logic              tail_valid;
  logic              tail_owner;
  logic              data_in_flight;

  // Data wins contention until the waiting fetch has seen STARVE_LIM data grants.
  always_comb begin
    inst_grant = 1'b0;
    data_grant = 1'b0;
    if (!rst) begin
      if (inst_req && data_req) begin
        if (streak_reg == STREAK_MAX) inst_grant = 1'b1;
        else                          data_grant = 1'b1;
      end else begin
        inst_grant = inst_req;
        data_grant = data_req;
      end
    end
  end

  always_comb begin
    streak_next = streak_reg;
    if (inst_grant || !inst_req)
      streak_next = 4'd0;
    else if (data_grant && (streak_reg != STREAK_MAX))
      streak_next = streak_reg + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) streak_reg <= 4'd0;
    else     streak_reg <= streak_next;
  end

  assign read_issue = inst_grant | (data_grant & (data_wen == 4'b0000));

  // Owner pipeline: stage 0 takes the new issue, the tail lines up with ram_rdata.
  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_owner_pipe
      if (gi == 0) begin : g_head
        assign valid_next[gi] = read_issue;
        assign owner_next[gi] = read_issue & data_grant;
      end else begin : g_shift
        assign valid_next[gi] = valid_reg[gi-1];
        assign owner_next[gi] = owner_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      owner_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      owner_reg <= owner_next;
    end
  end

  assign tail_valid     = valid_reg[RD_LAT-1];
  assign tail_owner     = owner_reg[RD_LAT-1];
  assign data_in_flight = |(valid_reg & owner_reg);

  assign inst_ack    = inst_grant;
  assign data_ack    = data_grant;
  assign inst_rvalid = ~rst & tail_valid & ~tail_owner;
  assign data_rvalid = ~rst & tail_valid & tail_owner;
  assign inst_rdata  = inst_rvalid ? ram_rdata : 32'd0;
  assign data_rdata  = data_rvalid ? ram_rdata : 32'd0;
  assign if_stall    = ~rst & inst_req & ~inst_grant;
  assign mem_stall   = ~rst & ((data_req & ~data_grant) | data_in_flight);

  always_comb begin
    ram_en     = 1'b0;
    ram_wen    = 4'b0000;
    grant_addr = 32'd0;
    ram_wdata  = 32'd0;
    if (inst_grant) begin
      ram_en     = 1'b1;
      grant_addr = inst_addr;
    end else if (data_grant) begin
      ram_en     = 1'b1;
      ram_wen    = data_wen;
      grant_addr = data_addr;
      ram_wdata  = data_wdata;
    end
  end

`ifdef ARB_KSEG_MAP_EN
  assign ram_addr = grant_addr & 32'h1FFF_FFFF;
`else
  assign ram_addr = grant_addr;
`endif

endmodule

// File: doc/unified_sram_arbiter.md
# unified_sram_arbiter

Shares one single-ported synchronous SRAM between the instruction-fetch path (pc_reg/if_id) and the data path (mem stage) of the 5-stage MIPS core. Each cycle it grants at most one requester and drives the shared SRAM port. A fixed-latency owner pipeline routes each read response back to the requester that issued it. The block produces the fetch-side and mem-side stall requests consumed by the pipeline stall controller.

## Interface
- RD_LAT, 1, SRAM read latency in cycles from issue to valid `ram_rdata` (legal 1..4)
- STARVE_LIM, 4, consecutive data grants allowed while a fetch waits (legal 1..15)
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- inst_req  in  1  fetch request; held until `inst_ack`
- inst_addr  in  32  fetch address
- inst_ack  out  1  fetch issued this cycle
- inst_rvalid  out  1  fetch data valid
- inst_rdata  out  32  fetch data
- data_req  in  1  load/store request; held until `data_ack`
- data_wen  in  4  byte write enables; 4'b0000 = read
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_ack  out  1  data access issued this cycle
- data_rvalid  out  1  load data valid
- data_rdata  out  32  load data
- ram_en  out  1  SRAM enable
- ram_wen  out  4  SRAM byte write enables
- ram_addr  out  32  SRAM address
- ram_wdata  out  32  SRAM write data
- ram_rdata  in  32  SRAM read data
- if_stall  out  1  fetch stall request
- mem_stall  out  1  mem-stage stall request

## Operation
- Grant selection is combinational from the requests and `streak`:
  - only one request asserted: grant it;
  - both asserted: grant data, unless `streak == STARVE_LIM`, in which case grant inst.
- Starvation counter `streak` (4-bit register):
  - +1 on a data grant while `inst_req = 1`;
  - cleared on an inst grant, or in any cycle with `inst_req = 0`;
  - saturates at STARVE_LIM.
- SRAM port drive:
  - granted requester drives `ram_en = 1`, `ram_addr`, `ram_wen` (inst grant: 4'b0000), `ram_wdata` (inst grant: 0);
  - no grant: `ram_en = 0`, `ram_wen = 0`, `ram_addr = 0`, `ram_wdata = 0`.
- `inst_ack` / `data_ack` equal the corresponding grant in the same cycle.
- Owner pipeline: an RD_LAT-deep shift register of {valid, owner}.
  - A read issue (inst grant, or data grant with `data_wen = 0`) enters {1, owner}; all other cycles enter {0, x}.
  - At the tail, a valid entry asserts `inst_rvalid` or `data_rvalid` for one cycle, with that port's rdata = `ram_rdata`.
  - The non-owner rdata output is held at 0.
- Writes produce no rvalid; `data_ack` is the store's completion.
- Stall outputs:
  - `if_stall = inst_req & ~inst_ack`;
  - `mem_stall = (data_req & ~data_ack) | (a data read is in flight in the owner pipeline)`.

## Timing
- Request to ack: 0 cycles (same cycle) when granted.
- Read ack to rvalid: exactly RD_LAT cycles; rvalid is a single-cycle pulse.
- A new grant may be issued every cycle. Responses keep issue order, and inst/data responses interleave correctly.
- Requester obligations:
  - addr, wen and wdata stay stable while req is high and ack is low;
  - dropping req before ack is legal and cancels the request with no side effects.
- Simultaneous read issue and tail response in the same cycle: both happen; the shift register advances normally.
- Reset:
  - while `rst = 1`, every output is 0 and `streak` = 0;
  - the owner pipeline is cleared, so reads in flight when rst asserts never produce rvalid;
  - the first grant is possible in the cycle after rst deasserts.
- `streak` boundary: with both requests held continuously, the grant pattern is STARVE_LIM data grants, then 1 inst grant, repeating.

## Configuration
- `ARB_KSEG_MAP_EN` defined:
  - `ram_addr = {3'b000, addr[28:0]}`, so kseg0 and kseg1 addresses alias onto physical SRAM;
  - applies to both requesters.
- Undefined: `ram_addr` = granted address unmodified.
- Grant, latency and stall behaviour are identical in both builds.

## Test plan
- Reset mid-read: RD_LAT=2, data read issued, rst asserted the next cycle -> no `data_rvalid` ever appears for that read; all outputs 0 during reset.
- Fetch only: `inst_req` held, `inst_addr = 0x00001000`, `ram_rdata = 0x24080001` at the latency point -> `inst_ack` in the same cycle; `inst_rvalid` with `inst_rdata = 0x24080001` exactly RD_LAT cycles later; `if_stall = 0`.
- Store then load: store `wen = 4'b0011`, `addr = 0x10`, `wdata = 0xDEADBEEF`; next cycle load from `0x10` -> `ram_wen = 4'b0011` on cycle 0; `data_rvalid` on cycle 1+RD_LAT; no rvalid for the store.
- Contention, STARVE_LIM=4, both requests held 10 cycles -> grants D,D,D,D,I,D,D,D,D,I; `if_stall = 1` exactly on the eight data-grant cycles.
- Interleaved responses, RD_LAT=3, grants I,D,I on consecutive cycles -> rvalid pulses inst, data, inst on cycles 3, 4, 5, each carrying its own `ram_rdata`.
- Macro: data read at `0xBFC00010` -> `ram_addr = 0x1FC00010` with `ARB_KSEG_MAP_EN`, `0xBFC00010` without.
